mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the instruction-fetch port, the data (MEM-stage) port and the
// unified single-port memory bus seen by mem_port_arbiter.
//   slave  : view taken by the arbiter (requests in, stalls/results/bus out)
//   master : view taken by the pipeline/memory model driving the arbiter
// Signals:
//   inst_ren, inst_addr      fetch request and address
//   inst_data, inst_stall    registered fetched word, fetch-incomplete flag
//   mem_ren, mem_wen         data read / write request
//   mem_addr, mem_dout       data address and store data
//   mem_din, mem_stall       registered load data, access-incomplete flag
//   bus_req, bus_we          registered memory request and write strobe
//   bus_addr, bus_wdata      registered memory address and write data
//   bus_ack, bus_rdata       memory completion and same-cycle read data
//   bus_err                  sticky timeout flag
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if;
    logic        inst_ren;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        inst_stall;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport slave (
        input  inst_ren, inst_addr, mem_ren, mem_wen, mem_addr, mem_dout,
        input  bus_ack, bus_rdata,
        output inst_data, inst_stall, mem_din, mem_stall,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_err
    );

    modport master (
        output inst_ren, inst_addr, mem_ren, mem_wen, mem_addr, mem_dout,
        output bus_ack, bus_rdata,
        input  inst_data, inst_stall, mem_din, mem_stall,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory bus between the instruction-fetch port and
// the MEM-stage data port of a pipelined core. Data accesses win over
// fetches; each port is served at most once per pipeline step, and a step
// ends on the first cycle in which neither port stalls. A bus transaction
// that sees no bus_ack for TIMEOUT+1 cycles is aborted, a read returns zero
// and the sticky bus_err flag is raised.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   port   mem_port_arbiter_if.slave (fetch port, data port, memory bus)
// Parameter:
//   TIMEOUT  bus cycles without bus_ack before an abort
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input logic              clk,
    input logic              rst_n,
    mem_port_arbiter_if.slave port
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_INST = 2'd2
    } state_t;

    state_t      state_q,     state_d;
    logic        bus_req_q,   bus_req_d;
    logic        bus_we_q,    bus_we_d;
    logic [31:0] bus_addr_q,  bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] inst_data_q, inst_data_d;
    logic [31:0] mem_din_q,   mem_din_d;
    logic        inst_done_q, inst_done_d;
    logic        mem_done_q,  mem_done_d;
    logic [7:0]  cnt_q,       cnt_d;
    logic        bus_err_q,   bus_err_d;

    logic data_pend;
    logic inst_pend;
    logic advance;

    assign data_pend = (port.mem_ren | port.mem_wen) & ~mem_done_q;
    assign inst_pend = port.inst_ren & ~inst_done_q;
    assign advance   = ~data_pend & ~inst_pend;

    assign port.inst_stall = inst_pend;
    assign port.mem_stall  = data_pend;
    assign port.bus_req    = bus_req_q;
    assign port.bus_we     = bus_we_q;
    assign port.bus_addr   = bus_addr_q;
    assign port.bus_wdata  = bus_wdata_q;
    assign port.inst_data  = inst_data_q;
    assign port.mem_din    = mem_din_q;
    assign port.bus_err    = bus_err_q;

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        inst_data_d = inst_data_q;
        mem_din_d   = mem_din_q;
        inst_done_d = inst_done_q;
        mem_done_d  = mem_done_q;
        cnt_d       = cnt_q;
        bus_err_d   = bus_err_q;

        // Pipeline step boundary: both ports become eligible again.
        if (advance) begin
            inst_done_d = 1'b0;
            mem_done_d  = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (data_pend) begin
                    // A simultaneous read+write request is issued as a write.
                    state_d     = ST_DATA;
                    bus_req_d   = 1'b1;
                    bus_we_d    = port.mem_wen;
                    bus_addr_d  = port.mem_addr;
                    bus_wdata_d = port.mem_dout;
                    cnt_d       = 8'd0;
                end else if (inst_pend) begin
                    state_d    = ST_INST;
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_addr_d = port.inst_addr;
                    cnt_d      = 8'd0;
                end else begin
                    bus_req_d = 1'b0;
                end
            end

            ST_DATA, ST_INST: begin
                if (port.bus_ack || (cnt_q == TIMEOUT)) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    if (!port.bus_ack) begin
                        bus_err_d = 1'b1;
                    end
                    // A timed-out read returns zero instead of bus data.
                    if (state_q == ST_DATA) begin
                        if (!bus_we_q) begin
                            mem_din_d = port.bus_ack ? port.bus_rdata : 32'h0;
                        end
                        // If the requester already dropped its request the
                        // step has ended; do not carry the flag into the next.
                        if (!advance) begin
                            mem_done_d = 1'b1;
                        end
                    end else begin
                        inst_data_d = port.bus_ack ? port.bus_rdata : 32'h0;
                        if (!advance) begin
                            inst_done_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
                bus_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            inst_data_q <= 32'h0;
            mem_din_q   <= 32'h0;
            inst_done_q <= 1'b0;
            mem_done_q  <= 1'b0;
            cnt_q       <= 8'd0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            inst_data_q <= inst_data_d;
            mem_din_q   <= mem_din_d;
            inst_done_q <= inst_done_d;
            mem_done_q  <= mem_done_d;
            cnt_q       <= cnt_d;
            bus_err_q   <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter (TIMEOUT=4). Expected bus transactions
// are queued when requests are driven and compared when bus_req appears.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_wd;
    } txn_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    txn_t sb[$];

    mem_port_arbiter_if bif ();

    mem_port_arbiter #(.TIMEOUT(8'd4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .port  (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit chk_wd);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.chk_wd = chk_wd;
        sb.push_back(t);
    endtask

    // Wait for the next bus transaction, compare it against the scoreboard,
    // then acknowledge it after 'lat' extra cycles with read data 'rdata'.
    task automatic serve(input int lat, input logic [31:0] rdata, input string tag);
        int   waits;
        txn_t t;
        waits = 0;
        do begin
            cyc();
            waits++;
        end while (bif.bus_req !== 1'b1 && waits < 20);
        chk({tag, " issue latency"}, waits, 1);
        chk({tag, " sb entry"}, (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) begin
            t = sb.pop_front();
            chk({tag, " bus_addr"}, bif.bus_addr, t.addr);
            chk({tag, " bus_we"}, bif.bus_we, t.we);
            if (t.chk_wd) chk({tag, " bus_wdata"}, bif.bus_wdata, t.wdata);
        end
        for (int i = 0; i < lat; i++) begin
            cyc();
            chk({tag, " bus_req held"}, bif.bus_req, 1);
        end
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = rdata;
        cyc();
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = 32'h0;
        chk({tag, " bus_req dropped"}, bif.bus_req, 0);
        chk({tag, " bus_we dropped"}, bif.bus_we, 0);
    endtask

    initial begin
        int n;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        bif.inst_ren  = 1'b0;
        bif.inst_addr = 32'h0;
        bif.mem_ren   = 1'b0;
        bif.mem_wen   = 1'b0;
        bif.mem_addr  = 32'h0;
        bif.mem_dout  = 32'h0;
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = 32'h0;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst bus_req", bif.bus_req, 0);
        chk("rst bus_we", bif.bus_we, 0);
        chk("rst bus_addr", bif.bus_addr, 0);
        chk("rst bus_wdata", bif.bus_wdata, 0);
        chk("rst inst_data", bif.inst_data, 0);
        chk("rst mem_din", bif.mem_din, 0);
        chk("rst bus_err", bif.bus_err, 0);
        chk("rst inst_stall", bif.inst_stall, 0);
        chk("rst mem_stall", bif.mem_stall, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Fetch only
        bif.inst_ren  = 1'b1;
        bif.inst_addr = 32'h40;
        #1;
        chk("fetch stall comb", bif.inst_stall, 1);
        push(1'b0, 32'h40, 32'h0, 1'b0);
        serve(0, 32'h2008_0005, "fetch");
        chk("fetch stall released", bif.inst_stall, 0);
        chk("fetch inst_data", bif.inst_data, 32'h2008_0005);
        bif.inst_ren = 1'b0;
        cyc();

        // Simultaneous fetch and load: data first, one IDLE cycle, then fetch
        bif.inst_ren  = 1'b1;
        bif.inst_addr = 32'h44;
        bif.mem_ren   = 1'b1;
        bif.mem_addr  = 32'h100;
        push(1'b0, 32'h100, 32'h0, 1'b0);
        push(1'b0, 32'h44, 32'h0, 1'b0);
        #1;
        chk("both mem_stall", bif.mem_stall, 1);
        chk("both inst_stall", bif.inst_stall, 1);
        serve(1, 32'hAAAA_5555, "both data");
        chk("both mem_din", bif.mem_din, 32'hAAAA_5555);
        chk("both mem_stall after data", bif.mem_stall, 0);
        chk("both inst_stall held", bif.inst_stall, 1);
        serve(0, 32'h1234_5678, "both inst");
        chk("both inst_data", bif.inst_data, 32'h1234_5678);
        chk("both inst_stall released", bif.inst_stall, 0);
        chk("both mem_stall stays low", bif.mem_stall, 0);
        bif.inst_ren = 1'b0;
        bif.mem_ren  = 1'b0;
        cyc();

        // Store
        bif.mem_wen  = 1'b1;
        bif.mem_addr = 32'h8;
        bif.mem_dout = 32'hDEAD_BEEF;
        push(1'b1, 32'h8, 32'hDEAD_BEEF, 1'b1);
        serve(2, 32'hFFFF_FFFF, "store");
        chk("store mem_din unchanged", bif.mem_din, 32'hAAAA_5555);
        chk("store mem_stall", bif.mem_stall, 0);
        bif.mem_wen = 1'b0;
        cyc();

        // Read and write together behave as a write
        bif.mem_ren  = 1'b1;
        bif.mem_wen  = 1'b1;
        bif.mem_addr = 32'hC;
        bif.mem_dout = 32'h0BAD_F00D;
        push(1'b1, 32'hC, 32'h0BAD_F00D, 1'b1);
        serve(0, 32'h7777_7777, "rw");
        chk("rw mem_din unchanged", bif.mem_din, 32'hAAAA_5555);
        bif.mem_ren = 1'b0;
        bif.mem_wen = 1'b0;
        cyc();
        chk("bus_err clear before timeout", bif.bus_err, 0);

        // Timeout on a fetch: TIMEOUT=4 gives five bus_req cycles
        bif.inst_ren  = 1'b1;
        bif.inst_addr = 32'h80;
        push(1'b0, 32'h80, 32'h0, 1'b0);
        cyc();
        chk("tmo bus_req", bif.bus_req, 1);
        if (sb.size() > 0) chk("tmo bus_addr", bif.bus_addr, sb.pop_front().addr);
        n = 0;
        while (bif.bus_req === 1'b1 && n < 20) begin
            n++;
            cyc();
        end
        chk("tmo req cycles", n, 5);
        chk("tmo bus_err", bif.bus_err, 1);
        chk("tmo inst_data", bif.inst_data, 0);
        chk("tmo inst_stall", bif.inst_stall, 0);
        bif.inst_ren = 1'b0;
        cyc();

        // Sticky error survives a normal transaction
        bif.mem_ren  = 1'b1;
        bif.mem_addr = 32'h300;
        push(1'b0, 32'h300, 32'h0, 1'b0);
        serve(1, 32'hCAFE_0001, "post tmo");
        chk("post tmo mem_din", bif.mem_din, 32'hCAFE_0001);
        chk("bus_err sticky", bif.bus_err, 1);
        bif.mem_ren = 1'b0;
        cyc();

        // Reset mid-transaction, then the same request is re-issued
        bif.mem_ren  = 1'b1;
        bif.mem_addr = 32'h200;
        cyc();
        chk("rstmid bus_req", bif.bus_req, 1);
        chk("rstmid bus_addr", bif.bus_addr, 32'h200);
        rst_n = 1'b0;
        #1;
        chk("rstmid bus_req async", bif.bus_req, 0);
        chk("rstmid bus_addr", bif.bus_addr, 0);
        chk("rstmid mem_din", bif.mem_din, 0);
        chk("rstmid bus_err", bif.bus_err, 0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("rstmid mem_stall follows req", bif.mem_stall, 1);
        push(1'b0, 32'h200, 32'h0, 1'b0);
        serve(0, 32'h0000_0055, "reissue");
        chk("reissue mem_din", bif.mem_din, 32'h0000_0055);
        chk("reissue mem_stall", bif.mem_stall, 0);
        chk("reissue bus_err", bif.bus_err, 0);
        bif.mem_ren = 1'b0;
        cyc();
        chk("sb drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
